debug_trace_buffer: RTL and testbench

Parametrised debug probe unit for the pipelined CPU: a registered live view of one selectable channel from a bus of NCH probe channels, plus a triggered circular trace buffer. The buffer records one selected channel every enabled sample cycle and freezes a configurable number of samples after a masked-compare trigger. It sits between the CPU's probe signals (PC/inst per stage, ALU, memory, control) and the board debug/VGA readout, replacing the purely combinational per-address selector.

---
 rtl/debug_trace_buffer_if.sv | 62 ++++++
 rtl/debug_trace_buffer.sv | 156 +++++++++++++++
 tb/tb_debug_trace_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// debug_trace_buffer_if
//
// Bundles the probe, live-view, trigger, capture-control and readout signals
// of the debug trace buffer so that they can be passed as one port.
//
//   probe_bus  NCH*W  probe channels, channel i at [i*W +: W]
//   sel        CW     live-view channel select
//   live_data  W      registered live view of channel sel
//   sample_en  1      qualifies a sample cycle
//   cap_ch     CW     channel recorded into the buffer
//   trig_ch    CW     channel compared for the trigger
//   trig_val   W      trigger compare value
//   trig_mask  W      trigger compare mask (1 = bit compared)
//   post_cnt   AW     samples recorded after the trigger sample
//   arm        1      start/restart pulse
//   rd_addr    AW     readout index, 0 = oldest valid sample
//   rd_data    W      registered readout
//   state      2      0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   done       1      high while state is DONE
//   count      AW+1   valid entries, saturates at DEPTH
//   trig_idx   AW     readout index of the trigger sample
//
// master: probe source / debug host side. slave: the trace buffer.
// -----------------------------------------------------------------------------
interface debug_trace_buffer_if #(
    parameter int NCH   = 32,
    parameter int W     = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);

    logic [NCH*W-1:0] probe_bus;
    logic [CW-1:0]    sel;
    logic [W-1:0]     live_data;
    logic             sample_en;
    logic [CW-1:0]    cap_ch;
    logic [CW-1:0]    trig_ch;
    logic [W-1:0]     trig_val;
    logic [W-1:0]     trig_mask;
    logic [AW-1:0]    post_cnt;
    logic             arm;
    logic [AW-1:0]    rd_addr;
    logic [W-1:0]     rd_data;
    logic [1:0]       state;
    logic             done;
    logic [AW:0]      count;
    logic [AW-1:0]    trig_idx;

    modport master (
        output probe_bus, sel, sample_en, cap_ch, trig_ch, trig_val,
               trig_mask, post_cnt, arm, rd_addr,
        input  live_data, rd_data, state, done, count, trig_idx
    );

    modport slave (
        input  probe_bus, sel, sample_en, cap_ch, trig_ch, trig_val,
               trig_mask, post_cnt, arm, rd_addr,
        output live_data, rd_data, state, done, count, trig_idx
    );
endinterface

// File: rtl/debug_trace_buffer.sv
// -----------------------------------------------------------------------------
// debug_trace_buffer
//
// Debug probe unit for the pipelined CPU. Provides a registered live view of
// one selectable probe channel and a triggered circular trace buffer that
// records one channel per enabled sample cycle, then freezes post_cnt samples
// after a masked-compare trigger.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    debug_trace_buffer_if.slave (probe, trigger, capture, readout)
// -----------------------------------------------------------------------------
module debug_trace_buffer #(
    parameter int NCH   = 32,
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    debug_trace_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]    state_q,    state_d;
    logic [AW-1:0] wp_q,       wp_d;
    logic [AW:0]   count_q,    count_d;
    logic [AW-1:0] post_q,     post_d;
    logic [AW-1:0] remain_q,   remain_d;
    logic [AW-1:0] trig_idx_q, trig_idx_d;
    logic [W-1:0]  live_q,     live_d;
    logic [W-1:0]  rd_q,       rd_d;

    // Trace storage is deliberately not reset; count gates every readout.
    logic [W-1:0]  mem_q [DEPTH];

    logic          wr_en;
    logic [W-1:0]  cap_data;
    logic [W-1:0]  trig_data;
    logic          match;
    logic [AW:0]   count_inc;
    logic [AW-1:0] base;
    logic [AW-1:0] rd_idx;

    always_comb begin
        cap_data  = bus.probe_bus[int'(bus.cap_ch) * W +: W];
        trig_data = bus.probe_bus[int'(bus.trig_ch) * W +: W];
        match     = ((trig_data ^ bus.trig_val) & bus.trig_mask) == '0;
        count_inc = (count_q == FULL) ? count_q : count_q + 1'b1;
    end

    // Once the buffer has wrapped, the oldest sample sits at the write pointer.
    always_comb begin
        base   = (count_q == FULL) ? wp_q : '0;
        rd_idx = base + bus.rd_addr;
        rd_d   = ({1'b0, bus.rd_addr} < count_q) ? mem_q[rd_idx] : '0;
        live_d = bus.probe_bus[int'(bus.sel) * W +: W];
    end

    // Capture control. arm wins over everything, including an enabled sample
    // in the same cycle. trig_idx is taken from the count that includes the
    // final sample, so it lands on the trigger sample in readout order.
    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        count_d    = count_q;
        post_d     = post_q;
        remain_d   = remain_q;
        trig_idx_d = trig_idx_q;
        wr_en      = 1'b0;

        if (bus.arm) begin
            wp_d    = '0;
            count_d = '0;
            post_d  = bus.post_cnt;
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (bus.sample_en) begin
                        wr_en   = 1'b1;
                        wp_d    = wp_q + 1'b1;
                        count_d = count_inc;
                        if (match) begin
                            if (post_q == '0) begin
                                state_d    = ST_DONE;
                                trig_idx_d = count_inc[AW-1:0] - AW'(1) - post_q;
                            end else begin
                                state_d  = ST_POST;
                                remain_d = post_q;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (bus.sample_en) begin
                        wr_en    = 1'b1;
                        wp_d     = wp_q + 1'b1;
                        count_d  = count_inc;
                        remain_d = remain_q - 1'b1;
                        if (remain_q == AW'(1)) begin
                            state_d    = ST_DONE;
                            trig_idx_d = count_inc[AW-1:0] - AW'(1) - post_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            count_q    <= '0;
            post_q     <= '0;
            remain_q   <= '0;
            trig_idx_q <= '0;
            live_q     <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            post_q     <= post_d;
            remain_q   <= remain_d;
            trig_idx_q <= trig_idx_d;
            live_q     <= live_d;
            rd_q       <= rd_d;
        end
    end

    // Storage write; the readout above sees the pre-edge content.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= cap_data;
        end
    end

    assign bus.live_data = live_q;
    assign bus.rd_data   = rd_q;
    assign bus.state     = state_q;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.count     = count_q;
    assign bus.trig_idx  = trig_idx_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_debug_trace_buffer
//
// Drives debug_trace_buffer through directed scenarios and a random soak.
// A reference model keeps every recorded sample in a queue and derives the
// expected outputs; a monitor process compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_debug_trace_buffer;
    localparam int NCH   = 32;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(NCH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    debug_trace_buffer_if #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dbg ();

    debug_trace_buffer #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dbg)
    );

    typedef struct {
        int           edge_no;
        logic [W-1:0] live;
        logic [W-1:0] rd;
        int           st;
        int           cnt;
        int           tidx;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    // Reference model: the full list of samples since the last arm.
    logic [W-1:0] rec[$];
    int m_state;
    int m_post;
    int m_remain;
    int m_trig_abs;

    // Counts clock edges so that expectations can name the edge they follow.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s @edge %0d: got 0x%0h expected 0x%0h",
                     name, edge_cnt, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] chan(input int ch);
        return dbg.probe_bus[ch*W +: W];
    endfunction

    function automatic int m_count();
        return (rec.size() < DEPTH) ? rec.size() : DEPTH;
    endfunction

    function automatic int m_start();
        return (rec.size() > DEPTH) ? rec.size() - DEPTH : 0;
    endfunction

    function automatic logic [W-1:0] m_read(input int a);
        if (a < m_count()) return rec[m_start() + a];
        return '0;
    endfunction

    task automatic modelReset();
        rec.delete();
        m_state    = 0;
        m_post     = 0;
        m_remain   = 0;
        m_trig_abs = 0;
    endtask

    task automatic setChan(input int ch, input logic [W-1:0] v);
        dbg.probe_bus[ch*W +: W] = v;
    endtask

    task automatic randomProbes();
        for (int i = 0; i < NCH; i++) setChan(i, $urandom);
    endtask

    // Predicts the outputs after the coming edge from the current inputs,
    // queues the prediction, then advances to just after that edge.
    task automatic applyStimulus();
        exp_t e;
        e.edge_no = edge_cnt + 1;
        if (!rst_n) begin
            modelReset();
            e.live = '0;
            e.rd   = '0;
        end else begin
            e.live = chan(int'(dbg.sel));
            e.rd   = m_read(int'(dbg.rd_addr));
            if (dbg.arm) begin
                rec.delete();
                m_state = 1;
                m_post  = int'(dbg.post_cnt);
            end else if (dbg.sample_en && (m_state == 1 || m_state == 2)) begin
                rec.push_back(chan(int'(dbg.cap_ch)));
                if (m_state == 1) begin
                    if (((chan(int'(dbg.trig_ch)) ^ dbg.trig_val) & dbg.trig_mask) == '0) begin
                        m_trig_abs = rec.size() - 1;
                        if (m_post == 0) m_state = 3;
                        else begin
                            m_state  = 2;
                            m_remain = m_post;
                        end
                    end
                end else begin
                    m_remain--;
                    if (m_remain == 0) m_state = 3;
                end
            end
        end
        e.st   = m_state;
        e.cnt  = m_count();
        e.tidx = m_trig_abs - m_start();
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset half-way through a cycle and checks that the outputs
    // clear before any clock edge arrives.
    task automatic assertResetMidCycle();
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_state", dbg.state, 0);
        checkOutput("async_rst_done", dbg.done, 0);
        checkOutput("async_rst_count", dbg.count, 0);
        checkOutput("async_rst_live", dbg.live_data, 0);
        checkOutput("async_rst_rd", dbg.rd_data, 0);
        e.edge_no = edge_cnt + 1;
        e.live = '0;
        e.rd   = '0;
        e.st   = 0;
        e.cnt  = 0;
        e.tidx = 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every prediction whose edge has passed.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            checkOutput("live_data", dbg.live_data, e.live);
            checkOutput("rd_data", dbg.rd_data, e.rd);
            checkOutput("state", dbg.state, e.st);
            checkOutput("done", dbg.done, (e.st == 3) ? 1 : 0);
            checkOutput("count", dbg.count, e.cnt);
            if (e.st == 3) checkOutput("trig_idx", dbg.trig_idx, e.tidx[AW-1:0]);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [W-1:0] last_cap;
        modelReset();
        randomProbes();
        dbg.sel       = '0;
        dbg.sample_en = 1'b0;
        dbg.cap_ch    = '0;
        dbg.trig_ch   = '0;
        dbg.trig_val  = '0;
        dbg.trig_mask = '0;
        dbg.post_cnt  = '0;
        dbg.arm       = 1'b0;
        dbg.rd_addr   = '0;
        @(posedge clk);
        #1;

        // Held reset, then release with no arm.
        repeat (3) applyStimulus();
        rst_n = 1'b1;

        // Live view.
        for (int i = 0; i < NCH; i++) setChan(i, 32'h1000 + i);
        dbg.sel = 5'd5;
        applyStimulus();
        checkOutput("live_sel5", dbg.live_data, 32'h1005);
        dbg.sel = 5'd31;
        applyStimulus();
        checkOutput("live_sel31", dbg.live_data, 32'h101F);
        checkOutput("idle_after_release", dbg.state, 0);

        // Wrap capture: counter on ch0/ch1, trigger at 0x40, three post samples.
        randomProbes();
        dbg.cap_ch    = 5'd0;
        dbg.trig_ch   = 5'd1;
        dbg.trig_val  = 32'h40;
        dbg.trig_mask = 32'hFFFF_FFFF;
        dbg.post_cnt  = 4'd3;
        dbg.sample_en = 1'b1;
        dbg.arm       = 1'b1;
        applyStimulus();
        dbg.arm = 1'b0;
        for (int k = 0; k < 200 && m_state != 3; k++) begin
            setChan(0, k);
            setChan(1, k);
            applyStimulus();
        end
        checkOutput("wrap_state", dbg.state, 3);
        checkOutput("wrap_count", dbg.count, 16);
        checkOutput("wrap_trig_idx", dbg.trig_idx, 12);
        dbg.rd_addr = 4'd0;
        applyStimulus();
        checkOutput("wrap_rd0", dbg.rd_data, 32'h34);
        dbg.rd_addr = 4'd12;
        applyStimulus();
        checkOutput("wrap_rd12", dbg.rd_data, 32'h40);
        dbg.rd_addr = 4'd15;
        applyStimulus();
        checkOutput("wrap_rd15", dbg.rd_data, 32'h43);

        // Partial fill: trigger on the fifth sample, two post samples.
        dbg.trig_val = 32'h8000_ABCD;
        dbg.post_cnt = 4'd2;
        dbg.arm      = 1'b1;
        applyStimulus();
        dbg.arm  = 1'b0;
        last_cap = '0;
        for (int k = 0; k < 20 && m_state != 3; k++) begin
            randomProbes();
            setChan(1, (k == 4) ? 32'h8000_ABCD : ($urandom & 32'h7FFF_FFFF));
            last_cap = chan(0);
            applyStimulus();
        end
        checkOutput("partial_count", dbg.count, 7);
        checkOutput("partial_trig_idx", dbg.trig_idx, 4);
        dbg.rd_addr = 4'd6;
        applyStimulus();
        checkOutput("partial_rd6", dbg.rd_data, last_cap);
        for (int a = 7; a < DEPTH; a++) begin
            dbg.rd_addr = AW'(a);
            applyStimulus();
            checkOutput("partial_rd_empty", dbg.rd_data, 0);
        end

        // Gating: the match value only appears on disabled cycles.
        dbg.trig_val  = 32'h55;
        dbg.post_cnt  = 4'd0;
        dbg.arm       = 1'b1;
        applyStimulus();
        dbg.arm = 1'b0;
        for (int k = 0; k < 10; k++) begin
            randomProbes();
            dbg.sample_en = (k % 2 == 0);
            setChan(1, dbg.sample_en ? ($urandom | 32'h100) : 32'h55);
            applyStimulus();
        end
        checkOutput("gating_state", dbg.state, 1);
        checkOutput("gating_count", dbg.count, 5);

        // Minimum capture: zero mask triggers on the first enabled sample.
        dbg.sample_en = 1'b1;
        dbg.trig_mask = '0;
        dbg.arm       = 1'b1;
        applyStimulus();
        dbg.arm = 1'b0;
        randomProbes();
        applyStimulus();
        checkOutput("min_state", dbg.state, 3);
        checkOutput("min_done", dbg.done, 1);
        checkOutput("min_count", dbg.count, 1);
        checkOutput("min_trig_idx", dbg.trig_idx, 0);

        // Restart priority over an enabled sample and over a match.
        dbg.trig_mask = 32'hFFFF_FFFF;
        dbg.trig_val  = 32'h77;
        dbg.post_cnt  = 4'd5;
        dbg.arm       = 1'b1;
        applyStimulus();
        dbg.arm = 1'b0;
        setChan(1, 32'h77);
        applyStimulus();
        setChan(1, 32'h78);
        repeat (2) applyStimulus();
        checkOutput("restart_pre_state", dbg.state, 2);
        dbg.arm = 1'b1;
        applyStimulus();
        checkOutput("restart_post_state", dbg.state, 1);
        checkOutput("restart_post_count", dbg.count, 0);
        setChan(1, 32'h77);
        applyStimulus();
        checkOutput("restart_match_state", dbg.state, 1);
        checkOutput("restart_match_count", dbg.count, 0);
        dbg.arm = 1'b0;

        // Reset in the middle of POST.
        dbg.post_cnt = 4'd8;
        dbg.arm      = 1'b1;
        applyStimulus();
        dbg.arm = 1'b0;
        setChan(1, 32'h77);
        applyStimulus();
        setChan(1, 32'h12);
        repeat (2) applyStimulus();
        assertResetMidCycle();
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        repeat (3) begin
            randomProbes();
            applyStimulus();
        end
        checkOutput("post_reset_idle", dbg.state, 0);

        // Random soak.
        for (int k = 0; k < 400; k++) begin
            randomProbes();
            dbg.arm       = ($urandom_range(11) == 0);
            dbg.sample_en = $urandom_range(1);
            dbg.sel       = CW'($urandom);
            dbg.cap_ch    = CW'($urandom);
            dbg.trig_ch   = CW'($urandom);
            dbg.trig_val  = $urandom;
            dbg.trig_mask = $urandom & 32'h3;
            dbg.post_cnt  = AW'($urandom);
            dbg.rd_addr   = AW'($urandom);
            applyStimulus();
        end

        dbg.arm       = 1'b0;
        dbg.sample_en = 1'b0;
        repeat (2) applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
